// File: rtl/ksa_task.sv
// RC4 key-scheduling pass over the 256-byte S memory, started by startTask2a, ended by a stopTask2a pulse.
// Latency: 6 cycles per index, 256 indices; stopTask2a is high 1536 cycles after the start edge, for one cycle.
// Backpressure: none; the memory answers in fixed time and startTask2a is ignored outside IDLE.
module ksa_task #(
    parameter int KEY_W = 24
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             startTask2a,
    output logic             stopTask2a,
    input  logic [KEY_W-1:0] secret_key,
    output logic [7:0]       address,
    output logic [7:0]       data,
    output logic             wren,
    input  logic [7:0]       q
);

    typedef enum logic [2:0] {
        IDLE,
        RD_I,
        GET_I,
        RD_J,
        GET_J,
        WR_I,
        WR_J,
        DONE
    } state_t;

    state_t      state;
    state_t      nextState;
    logic [7:0]  i;
    logic [7:0]  j;
    logic [7:0]  si;
    logic [7:0]  sj;
    logic [1:0]  keyIdx;
    logic [7:0]  keyByte;

    // Key byte for the current index; the key is read most-significant byte first.
    always_comb begin
        keyByte = secret_key[7:0];
        case (keyIdx)
            2'd0:    keyByte = secret_key[23:16];
            2'd1:    keyByte = secret_key[15:8];
            default: keyByte = secret_key[7:0];
        endcase
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state decode plus the memory-port and stop outputs, all decoded from state.
    always_comb begin
        nextState  = state;
        address    = 8'd0;
        data       = 8'd0;
        wren       = 1'b0;
        stopTask2a = 1'b0;
        case (state)
            IDLE: begin
                if (startTask2a) begin
                    nextState = RD_I;
                end
            end
            RD_I: begin
                address   = i;
                nextState = GET_I;
            end
            GET_I: begin
                // Address held so the RAM keeps returning s[i] while it is captured.
                address   = i;
                nextState = RD_J;
            end
            RD_J: begin
                address   = j;
                nextState = GET_J;
            end
            GET_J: begin
                address   = j;
                nextState = WR_I;
            end
            WR_I: begin
                address   = i;
                data      = sj;
                wren      = 1'b1;
                nextState = WR_J;
            end
            WR_J: begin
                address   = j;
                data      = si;
                wren      = 1'b1;
                nextState = (i == 8'd255) ? DONE : RD_I;
            end
            DONE: begin
                stopTask2a = 1'b1;
                nextState  = IDLE;
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    // Datapath: index counters cleared while idle, swap operands captured from q.
    always_ff @(posedge clock) begin
        if (reset) begin
            i      <= 8'd0;
            j      <= 8'd0;
            si     <= 8'd0;
            sj     <= 8'd0;
            keyIdx <= 2'd0;
        end else begin
            case (state)
                IDLE: begin
                    i      <= 8'd0;
                    j      <= 8'd0;
                    keyIdx <= 2'd0;
                end
                GET_I: begin
                    si <= q;
                    j  <= j + q + keyByte;
                end
                GET_J: begin
                    sj <= q;
                end
                WR_J: begin
                    // i parks at 255 on the last index; leaving IDLE clears it again.
                    if (i != 8'd255) begin
                        i      <= i + 8'd1;
                        keyIdx <= (keyIdx == 2'd2) ? 2'd0 : keyIdx + 2'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/ksa_task.md
# ksa_task

Responder for the controller's Task 2a handshake: waits for a start pulse, runs the RC4 key-scheduling pass over the 256-byte S memory, then returns a one-cycle stop pulse to the controller. It owns the S-memory port for the whole pass and leaves S permuted in place. The block assumes the Task 1 responder has already initialised S to s[k] = k.

## Interface
- KEY_W, 24, secret key width; key length is fixed at 3 bytes.
- clock  in  1  system clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high; returns the block to IDLE.
- startTask2a  in  1  one-cycle start request from the controller.
- stopTask2a  out  1  one-cycle completion pulse to the controller.
- secret_key  in  24  key; must be stable from start until stop.
- address  out  8  S-memory address.
- data  out  8  S-memory write data.
- wren  out  1  S-memory write enable.
- q  in  8  S-memory read data; valid the cycle after the address is presented.

## Operation
- Key byte for index i: secret_key[23:16] when i mod 3 = 0, [15:8] when 1, [7:0] when 2.
- Registers: i (8 bit), j (8 bit), si, sj (8 bit), key-index counter (0..2, wraps), state.
- States and transitions:
  - IDLE: i=0, j=0, key index 0; startTask2a=1 -> RD_I; otherwise stay.
  - RD_I: address=i -> GET_I.
  - GET_I: si<=q; j<=j+q+keybyte (mod 256, carries dropped) -> RD_J.
  - RD_J: address=j -> GET_J.
  - GET_J: sj<=q -> WR_I.
  - WR_I: address=i, data=sj, wren=1 -> WR_J.
  - WR_J: address=j, data=si, wren=1. If i=255 -> DONE. Otherwise i<=i+1, key index advances -> RD_I.
  - DONE: stopTask2a=1 -> IDLE.
- i=j: both writes store the same value, and S is unchanged, as required.
- startTask2a is ignored outside IDLE. A pulse coincident with stopTask2a in DONE is also ignored.
- address, data and wren are decoded from state and registers.
  - wren=0 in every state except WR_I and WR_J.
  - address=0 and data=0 in IDLE and DONE.

## Timing
- Reset values: stopTask2a=0, wren=0, address=0, data=0, state=IDLE, i=0, j=0.
- Each iteration takes 6 cycles, RD_I through WR_J.
- Latency: the start is sampled at edge E. The first RD_I cycle follows E. stopTask2a is high for exactly one cycle, 1536 cycles after E, in DONE.
- Memory contract: the address is presented in cycle N and the RAM registers it at the end of N. q is sampled at the end of N+1.
- A write takes effect at the edge ending the WR cycle.
- Reset mid-pass: the next cycle is IDLE with all outputs at reset values. The memory is left partially permuted, and no stop is issued.
- Index wrap-around: i stops at 255, with no increment past it. j wraps modulo 256.

## Test plan
- Reset, then hold start low for 20 cycles: stopTask2a=0 and wren=0 throughout; address=0.
- S identity, key 0x000000, one start pulse. Iteration 0: j=0, no change. Iteration 1: j=1, no change. Iteration 2: j=3, giving s[2]=3 and s[3]=2. Write cycles are WR_I(addr 2, data 3) then WR_J(addr 3, data 2).
- S identity, key 0x010000, one start pulse. Iteration 0: j=1, giving s[0]=1 and s[1]=0. Compare the final S against the software RC4 KSA for the same key.
- Any key: stopTask2a rises exactly 1536 cycles after the start edge, lasts 1 cycle, and wren pulses exactly 512 times.
- Second start pulse 100 cycles into a pass: ignored. Exactly one stop, at cycle 1536.
- Assert reset at cycle 700 of a pass: IDLE next cycle, with stop=0 and wren=0. A new start afterwards completes in 1536 cycles with i and j restarted from 0.
